// File: rtl/controlpa200_if.sv
// controlpa200_if -- bundle between the sequencing controller and its
// neighbours (ADC capture side and the filtropa200 datapath).
//
//   habilitar   ctrl <-  enable for the sample-period counter
//   dato_listo  ctrl <-  ADC capture acknowledge (UK valid)
//   muestrear   ctrl ->  one-cycle ADC sample request
//   en1..en4    ctrl ->  datapath register enables (YK, FK, FK_1, FK_2)
//   muxS        ctrl ->  multiplicand select
//   muxC        ctrl ->  coefficient select
//   muxZ        ctrl ->  addend select
//   listo       ctrl ->  one-cycle pulse, YK holds the new sample
//   ocupado     ctrl ->  sequence in progress
//   sobrecarga  ctrl ->  sticky dropped-tick flag
//
// master = controller side, slave = datapath / environment side.
interface controlpa200_if;
  logic       habilitar;
  logic       dato_listo;
  logic       muestrear;
  logic       en1;
  logic       en2;
  logic       en3;
  logic       en4;
  logic [2:0] muxS;
  logic [1:0] muxC;
  logic [1:0] muxZ;
  logic       listo;
  logic       ocupado;
  logic       sobrecarga;

  modport master (
    input  habilitar, dato_listo,
    output muestrear, en1, en2, en3, en4, muxS, muxC, muxZ,
           listo, ocupado, sobrecarga
  );

  modport slave (
    output habilitar, dato_listo,
    input  muestrear, en1, en2, en3, en4, muxS, muxC, muxZ,
           listo, ocupado, sobrecarga
  );
endinterface

// File: rtl/controlpa200.sv
// controlpa200 -- sequencing control for the 200 Hz high-pass datapath.
//
// A free-running period counter produces one tick every DIV cycles. Each
// tick requests an ADC sample, waits for the acknowledge and then walks the
// datapath through a fixed seven-cycle multiply-accumulate schedule:
//   f(k) = u(k) - a1*f(k-1) - a2*f(k-2)
//   y(k) = b0*f(k) + b1*f(k-1) + b0*f(k-2)
// with the datapath computing resultado = muxS_operand * muxC_coef + muxZ_operand.
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high
//   bus    controlpa200_if.master (see interface header for signal list)
//
// Parameters:
//   DIV    clk cycles per sample period, DIV >= 12
//   ANCHO  period counter width, DIV <= 2**ANCHO
module controlpa200 #(
  parameter int DIV   = 5000,
  parameter int ANCHO = 16
) (
  input logic             clk,
  input logic             reset,
  controlpa200_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, SOLICITA, ESPERA, SHIFT, F1, F2, Y1, Y2, Y3, FIN
  } state_t;

  // All control outputs live in one packed word so the FSM can register
  // them as a unit alongside the state.
  typedef struct packed {
    logic       muestrear;
    logic       en1;
    logic       en2;
    logic       en3;
    logic       en4;
    logic [2:0] mux_s;
    logic [1:0] mux_c;
    logic [1:0] mux_z;
    logic       listo;
    logic       ocupado;
  } ctl_t;

  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(DIV - 1);

  logic [ANCHO-1:0] cuenta;
  logic             tick;
  state_t           state;
  state_t           nxt;
  ctl_t             ctl;
  logic             sobrecarga;

  // ---------------------------------------------------------------------
  // Sample-period counter. Held at zero while disabled so that re-enabling
  // always yields a full DIV-1 cycle wait before the next tick.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)                cuenta <= '0;
    else if (!bus.habilitar)  cuenta <= '0;
    else if (cuenta == ULTIMO) cuenta <= '0;
    else                      cuenta <= cuenta + 1'b1;
  end

  assign tick = (cuenta == ULTIMO) && bus.habilitar;

  // ---------------------------------------------------------------------
  // Moore decode: one entry per state. Mux selects stay 0 outside the
  // compute states; only one enable group is active per compute cycle.
  //   muxS: 0 UK, 1 fk, 2 fk1, 3 fk2, 4 yk
  //   muxC: 0 -a1, 1 -a2, 2 b0 (b2), 3 b1
  //   muxZ: 0 UK, 1 fk, 2 yk, 3 zero
  // ---------------------------------------------------------------------
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    c.ocupado = (s != IDLE);
    case (s)
      SOLICITA: c.muestrear = 1'b1;
      SHIFT: begin
        // fk1 <- fk and fk2 <- fk1 on the same edge, both using old values
        c.en3 = 1'b1;
        c.en4 = 1'b1;
      end
      F1: begin                          // fk <- -a1*fk1 + UK
        c.en2   = 1'b1;
        c.mux_s = 3'd2;
        c.mux_c = 2'd0;
        c.mux_z = 2'd0;
      end
      F2: begin                          // fk <- -a2*fk2 + fk
        c.en2   = 1'b1;
        c.mux_s = 3'd3;
        c.mux_c = 2'd1;
        c.mux_z = 2'd1;
      end
      Y1: begin                          // yk <- b0*fk + 0
        c.en1   = 1'b1;
        c.mux_s = 3'd1;
        c.mux_c = 2'd2;
        c.mux_z = 2'd3;
      end
      Y2: begin                          // yk <- b1*fk1 + yk
        c.en1   = 1'b1;
        c.mux_s = 3'd2;
        c.mux_c = 2'd3;
        c.mux_z = 2'd2;
      end
      Y3: begin                          // yk <- b0*fk2 + yk
        c.en1   = 1'b1;
        c.mux_s = 3'd3;
        c.mux_c = 2'd2;
        c.mux_z = 2'd2;
      end
      FIN:     c.listo = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Next-state logic. The acknowledge is only looked at in ESPERA; there
  // is no timeout, a missing ADC simply stalls the controller.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (tick) nxt = SOLICITA;
      SOLICITA: nxt = ESPERA;
      ESPERA:   if (bus.dato_listo) nxt = SHIFT;
      SHIFT:    nxt = F1;
      F1:       nxt = F2;
      F2:       nxt = Y1;
      Y1:       nxt = Y2;
      Y2:       nxt = Y3;
      Y3:       nxt = FIN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers. Outputs are registered from the decode of
  // the next state, so they always equal decode(state) and no input can
  // reach an output within the same cycle.
  // A tick seen outside IDLE (FIN included) is dropped and latched in the
  // sticky overrun flag; habilitar dropping mid-sequence does not abort.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ctl        <= '0;
      sobrecarga <= 1'b0;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
      if (tick && (state != IDLE)) sobrecarga <= 1'b1;
    end
  end

  assign bus.muestrear  = ctl.muestrear;
  assign bus.en1        = ctl.en1;
  assign bus.en2        = ctl.en2;
  assign bus.en3        = ctl.en3;
  assign bus.en4        = ctl.en4;
  assign bus.muxS       = ctl.mux_s;
  assign bus.muxC       = ctl.mux_c;
  assign bus.muxZ       = ctl.mux_z;
  assign bus.listo      = ctl.listo;
  assign bus.ocupado    = ctl.ocupado;
  assign bus.sobrecarga = sobrecarga;

endmodule

// File: tb/tb_controlpa200.sv
// tb_controlpa200 -- directed bench for controlpa200 with DIV=20.
// Includes a small integer model of the filtropa200 datapath so the
// impulse response can be compared against hand-computed samples.
module tb_controlpa200;
  localparam int DIV   = 20;
  localparam int ANCHO = 5;

  // datapath coefficients (integers, no scaling): -a1, -a2, b0, b1
  localparam int NA1 = 1;
  localparam int NA2 = -1;
  localparam int B0  = 2;
  localparam int B1  = -3;

  // control word: {muestrear, en1,en2,en3,en4, muxS, muxC, muxZ, listo, ocupado}
  localparam logic [13:0] C_IDLE = 14'd0;
  localparam logic [13:0] C_SOL  = {1'b1, 4'b0000, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1};
  localparam logic [13:0] C_ESP  = {1'b0, 4'b0000, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1};
  localparam logic [13:0] C_SHF  = {1'b0, 4'b0011, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1};
  localparam logic [13:0] C_F1   = {1'b0, 4'b0100, 3'd2, 2'd0, 2'd0, 1'b0, 1'b1};
  localparam logic [13:0] C_F2   = {1'b0, 4'b0100, 3'd3, 2'd1, 2'd1, 1'b0, 1'b1};
  localparam logic [13:0] C_Y1   = {1'b0, 4'b1000, 3'd1, 2'd2, 2'd3, 1'b0, 1'b1};
  localparam logic [13:0] C_Y2   = {1'b0, 4'b1000, 3'd2, 2'd3, 2'd2, 1'b0, 1'b1};
  localparam logic [13:0] C_Y3   = {1'b0, 4'b1000, 3'd3, 2'd2, 2'd2, 1'b0, 1'b1};
  localparam logic [13:0] C_FIN  = {1'b0, 4'b0000, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic reset;
  controlpa200_if bus();

  controlpa200 #(.DIV(DIV), .ANCHO(ANCHO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  int uk;
  int fk, fk1, fk2, yk;
  int op_s, op_c, op_z, res;

  always_comb begin
    op_s = 0;
    op_c = 0;
    op_z = 0;
    case (bus.muxS)
      3'd0: op_s = uk;
      3'd1: op_s = fk;
      3'd2: op_s = fk1;
      3'd3: op_s = fk2;
      3'd4: op_s = yk;
      default: op_s = 0;
    endcase
    case (bus.muxC)
      2'd0: op_c = NA1;
      2'd1: op_c = NA2;
      2'd2: op_c = B0;
      default: op_c = B1;
    endcase
    case (bus.muxZ)
      2'd0: op_z = uk;
      2'd1: op_z = fk;
      2'd2: op_z = yk;
      default: op_z = 0;
    endcase
    res = op_s * op_c + op_z;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0;
    end else begin
      if (bus.en3) fk1 <= fk;
      if (bus.en4) fk2 <= fk1;
      if (bus.en2) fk  <= res;
      if (bus.en1) yk  <= res;
    end
  end

  // ---------------- monitors ----------------
  int listo_cnt = 0;
  int excl_viol = 0;
  always @(posedge clk) begin
    if (bus.listo) listo_cnt <= listo_cnt + 1;
    if (bus.en1 && bus.en2) excl_viol <= excl_viol + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] ctl_word();
    return {bus.muestrear, bus.en1, bus.en2, bus.en3, bus.en4,
            bus.muxS, bus.muxC, bus.muxZ, bus.listo, bus.ocupado};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // edges until muestrear is seen, capped at lim
  task automatic wait_muestrear(output int n, input int lim);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.muestrear && n < lim);
  endtask

  task automatic wait_listo(output int n, input int lim);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.listo && n < lim);
  endtask

  // hand-computed y(k) for u = 1,0,0,... with the coefficients above
  int ygold [8] = '{2, -1, -1, 0, 1, 1, 0, -1};
  logic [13:0] seq [7] = '{C_SHF, C_F1, C_F2, C_Y1, C_Y2, C_Y3, C_FIN};

  initial begin
    int n;
    int lc0;
    int mcnt;

    reset = 1'b1;
    bus.habilitar  = 1'b0;
    bus.dato_listo = 1'b0;
    uk = 0;
    step();
    step();
    chk("rst_ctl", int'(ctl_word()), int'(C_IDLE));
    chk("rst_sobrecarga", int'(bus.sobrecarga), 0);

    // count a while, then reset mid-count for 3 cycles
    reset = 1'b0;
    bus.habilitar = 1'b1;
    repeat (7) step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold_ctl", int'(ctl_word()), int'(C_IDLE));
    end
    reset = 1'b0;
    wait_muestrear(n, 2 * DIV);
    chk("first_muestrear_lat", n, DIV);

    // nominal sequence, ack 2 cycles after the request, impulse sample 0
    lc0 = listo_cnt;
    chk("nom_sol", int'(ctl_word()), int'(C_SOL));
    step();
    chk("nom_esp1", int'(ctl_word()), int'(C_ESP));
    step();
    chk("nom_esp2", int'(ctl_word()), int'(C_ESP));
    bus.dato_listo = 1'b1;
    uk = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      bus.dato_listo = 1'b0;
      chk($sformatf("nom_seq%0d", i), int'(ctl_word()), int'(seq[i]));
    end
    chk("imp_y0", yk, ygold[0]);
    step();
    chk("nom_idle", int'(ctl_word()), int'(C_IDLE));
    chk("nom_listo_once", listo_cnt - lc0, 1);
    chk("nom_sobrecarga", int'(bus.sobrecarga), 0);

    // remaining impulse samples, immediate ack
    for (int k = 1; k < 8; k++) begin
      wait_muestrear(n, 2 * DIV);
      chk("imp_req_seen", int'(n < 2 * DIV), 1);
      step();
      bus.dato_listo = 1'b1;
      uk = 0;
      step();
      bus.dato_listo = 1'b0;
      wait_listo(n, 20);
      chk("imp_listo_seen", int'(n < 20), 1);
      chk($sformatf("imp_y%0d", k), yk, ygold[k]);
    end
    chk("imp_sobrecarga", int'(bus.sobrecarga), 0);

    // ack withheld for 25 cycles: a tick lands in ESPERA
    wait_muestrear(n, 2 * DIV);
    chk("ovr_req_seen", int'(n < 2 * DIV), 1);
    for (int i = 0; i < 25; i++) begin
      step();
      chk("ovr_esp", int'(ctl_word()), int'(C_ESP));
    end
    chk("ovr_sobrecarga", int'(bus.sobrecarga), 1);
    bus.dato_listo = 1'b1;
    step();
    bus.dato_listo = 1'b0;
    chk("ovr_shift", int'(ctl_word()), int'(C_SHF));
    wait_listo(n, 20);
    chk("ovr_listo_seen", int'(n < 20), 1);
    step();
    chk("ovr_idle", int'(ctl_word()), int'(C_IDLE));
    chk("ovr_sticky", int'(bus.sobrecarga), 1);

    // reset asserted in F2
    wait_muestrear(n, 2 * DIV);
    chk("rf2_req_seen", int'(n < 2 * DIV), 1);
    step();
    bus.dato_listo = 1'b1;
    step();
    bus.dato_listo = 1'b0;
    step();
    step();
    chk("rf2_in_f2", int'(ctl_word()), int'(C_F2));
    reset = 1'b1;
    step();
    chk("rf2_idle", int'(ctl_word()), int'(C_IDLE));
    chk("rf2_sobrecarga_clr", int'(bus.sobrecarga), 0);
    chk("rf2_yk_clr", yk, 0);
    lc0 = listo_cnt;
    reset = 1'b0;
    wait_muestrear(n, 2 * DIV);
    chk("rf2_muestrear_lat", n, DIV);
    chk("rf2_no_listo", listo_cnt - lc0, 0);

    // habilitar drops mid-sequence: sequence completes, then no requests
    bus.habilitar = 1'b0;
    step();
    bus.dato_listo = 1'b1;
    step();
    bus.dato_listo = 1'b0;
    wait_listo(n, 20);
    chk("hab_seq_completes", int'(n < 20), 1);
    mcnt = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      step();
      if (bus.muestrear) mcnt++;
    end
    chk("hab_no_muestrear", mcnt, 0);
    bus.habilitar = 1'b1;
    wait_muestrear(n, 2 * DIV);
    chk("hab_reenable_lat", n, DIV);

    chk("en1_en2_exclusive", excl_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
